// File: rtl/ctrl_pkg.sv
// Shared types and constants for the RISC-V control unit: control-word layout,
// FSM state encoding, ALU/load-store/write-source/branch codes and opcodes.
package ctrl_pkg;

  // Field order is the bit order of the 21-bit ctrl_signals bus, MSB first.
  typedef struct packed {
    logic       write_en;
    logic [3:0] alu_sel;
    logic       alu_b_sel;
    logic       alu_a_sel;
    logic       mem_write;
    logic       mem_read;
    logic [1:0] ls_type;
    logic       load_unsigned;
    logic [1:0] write_src_sel;
    logic [2:0] branch_type;
    logic       stay;
    logic       memcpy_store;
    logic       counter_en;
    logic       counter_sel;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_MC_LOAD  = 2'd2,
    ST_MC_STORE = 2'd3
  } state_t;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] LS_BYTE = 2'd0;
  localparam logic [1:0] LS_HALF = 2'd1;
  localparam logic [1:0] LS_WORD = 2'd2;

  localparam logic [1:0] WS_ALU = 2'd0;
  localparam logic [1:0] WS_MEM = 2'd1;
  localparam logic [1:0] WS_PC4 = 2'd2;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BGE  = 3'd4;
  localparam logic [2:0] BR_BLTU = 3'd5;
  localparam logic [2:0] BR_BGEU = 3'd6;
  localparam logic [2:0] BR_JUMP = 3'd7;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam ctrl_t CTRL_NOP = '0;

  // SUB only exists for register-register ops; shifts use funct7[5] in both forms.
  function automatic logic [3:0] alu_op(input logic [2:0] funct3,
                                        input logic       funct7_b5,
                                        input logic       is_reg);
    case (funct3)
      3'b000:  alu_op = (is_reg && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = funct7_b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  function automatic logic [2:0] branch_of(input logic [2:0] funct3);
    case (funct3)
      3'b000:  branch_of = BR_BEQ;
      3'b001:  branch_of = BR_BNE;
      3'b100:  branch_of = BR_BLT;
      3'b101:  branch_of = BR_BGE;
      3'b110:  branch_of = BR_BLTU;
      3'b111:  branch_of = BR_BGEU;
      default: branch_of = BR_NONE;
    endcase
  endfunction

  function automatic logic [1:0] ls_of(input logic [1:0] size);
    case (size)
      2'b00:   ls_of = LS_BYTE;
      2'b01:   ls_of = LS_HALF;
      default: ls_of = LS_WORD;
    endcase
  endfunction

  function automatic ctrl_t ctrl_boot();
    ctrl_t c;
    c      = CTRL_NOP;
    c.stay = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_mc_load();
    ctrl_t c;
    c               = CTRL_NOP;
    c.write_en      = 1'b1;
    c.write_src_sel = WS_MEM;
    c.mem_read      = 1'b1;
    c.alu_sel       = ALU_ADD;
    c.alu_b_sel     = 1'b1;
    c.counter_sel   = 1'b1;
    c.stay          = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_mc_store();
    ctrl_t c;
    c              = CTRL_NOP;
    c.mem_write    = 1'b1;
    c.alu_sel      = ALU_ADD;
    c.alu_b_sel    = 1'b1;
    c.counter_sel  = 1'b1;
    c.memcpy_store = 1'b1;
    c.counter_en   = 1'b1;
    c.stay         = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/ctrl_fsm_decode.sv
// Combinational single-cycle instruction decoder used in the EXEC state.
// Recognises the memcpy opcode only when CTRL_MEMCPY_EN is defined.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter logic [6:0] MC_OPCODE = 7'b0001011,
  parameter logic [2:0] MC_FUNCT3 = 3'b000
) (
  input  logic [31:0] instruction,
  output ctrl_t       ctrl,
  output logic        illegal,
  output logic        is_memcpy
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic [20:0] unused_instr_bits;

  assign opcode            = instruction[6:0];
  assign funct3            = instruction[14:12];
  assign funct7_b5         = instruction[30];
  assign unused_instr_bits = {instruction[31], instruction[29:15], instruction[11:7]};

`ifndef CTRL_MEMCPY_EN
  logic [9:0] unused_mc_id;
  assign unused_mc_id = {MC_OPCODE, MC_FUNCT3};
`endif

  always_comb begin
    ctrl      = CTRL_NOP;
    illegal   = 1'b0;
    is_memcpy = 1'b0;
    case (opcode)
      OP_REG: begin
        ctrl.write_en      = 1'b1;
        ctrl.write_src_sel = WS_ALU;
        ctrl.alu_sel       = alu_op(funct3, funct7_b5, 1'b1);
      end
      OP_IMM: begin
        ctrl.write_en      = 1'b1;
        ctrl.write_src_sel = WS_ALU;
        ctrl.alu_b_sel     = 1'b1;
        ctrl.alu_sel       = alu_op(funct3, funct7_b5, 1'b0);
      end
      OP_LUI: begin
        ctrl.write_en      = 1'b1;
        ctrl.write_src_sel = WS_ALU;
        ctrl.alu_sel       = ALU_PASSB;
        ctrl.alu_b_sel     = 1'b1;
      end
      OP_AUIPC: begin
        ctrl.write_en      = 1'b1;
        ctrl.write_src_sel = WS_ALU;
        ctrl.alu_sel       = ALU_ADD;
        ctrl.alu_a_sel     = 1'b1;
        ctrl.alu_b_sel     = 1'b1;
      end
      OP_LOAD: begin
        ctrl.write_en      = 1'b1;
        ctrl.write_src_sel = WS_MEM;
        ctrl.mem_read      = 1'b1;
        ctrl.alu_sel       = ALU_ADD;
        ctrl.alu_b_sel     = 1'b1;
        ctrl.ls_type       = ls_of(funct3[1:0]);
        ctrl.load_unsigned = funct3[2];
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_sel   = ALU_ADD;
        ctrl.alu_b_sel = 1'b1;
        ctrl.ls_type   = ls_of(funct3[1:0]);
      end
      OP_BRANCH: begin
        ctrl.alu_sel     = ALU_SUB;
        ctrl.branch_type = branch_of(funct3);
      end
      OP_JAL: begin
        ctrl.write_en      = 1'b1;
        ctrl.write_src_sel = WS_PC4;
        ctrl.branch_type   = BR_JUMP;
        ctrl.alu_sel       = ALU_ADD;
        ctrl.alu_a_sel     = 1'b1;
        ctrl.alu_b_sel     = 1'b1;
      end
      OP_JALR: begin
        ctrl.write_en      = 1'b1;
        ctrl.write_src_sel = WS_PC4;
        ctrl.branch_type   = BR_JUMP;
        ctrl.alu_sel       = ALU_ADD;
        ctrl.alu_b_sel     = 1'b1;
      end
      default: begin
`ifdef CTRL_MEMCPY_EN
        if (opcode == MC_OPCODE && funct3 == MC_FUNCT3) is_memcpy = 1'b1;
        else                                            illegal   = 1'b1;
`else
        illegal = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle control unit: boot bubble, single-cycle decode and memcpy load/store
// sequencing. The memcpy path is built only when CTRL_MEMCPY_EN is defined.
module ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter logic [6:0] MC_OPCODE = 7'b0001011,
  parameter logic [2:0] MC_FUNCT3 = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        ex_no_stay,
  output logic [20:0] ctrl_signals,
  output logic        illegal_instr,
  output logic        mc_active
);

  state_t state;
  ctrl_t  dec_ctrl;
  logic   dec_illegal;
  logic   dec_memcpy;
  ctrl_t  ctrl_word;
  ctrl_t  out_word;

  ctrl_decode #(
    .MC_OPCODE (MC_OPCODE),
    .MC_FUNCT3 (MC_FUNCT3)
  ) u_decode (
    .instruction (instruction),
    .ctrl        (dec_ctrl),
    .illegal     (dec_illegal),
    .is_memcpy   (dec_memcpy)
  );

  // The EXEC cycle that decodes memcpy already performs the first load,
  // so the sequence always continues in MC_STORE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_BOOT;
    end else begin
      case (state)
        ST_BOOT: state <= ST_EXEC;
`ifdef CTRL_MEMCPY_EN
        ST_EXEC:     state <= dec_memcpy ? ST_MC_STORE : ST_EXEC;
        ST_MC_LOAD:  state <= ST_MC_STORE;
        ST_MC_STORE: state <= ex_no_stay ? ST_EXEC : ST_MC_LOAD;
`else
        ST_EXEC:     state <= ST_EXEC;
`endif
        default: state <= ST_BOOT;
      endcase
    end
  end

`ifndef CTRL_MEMCPY_EN
  logic unused_ex_no_stay;
  assign unused_ex_no_stay = ex_no_stay;
`endif

  // Outputs are Mealy; reset overrides the state so the bus is quiet immediately.
  always_comb begin
    ctrl_word     = ctrl_boot();
    illegal_instr = 1'b0;
    mc_active     = 1'b0;
    if (!rst) begin
      case (state)
        ST_EXEC: begin
          if (dec_memcpy) begin
            ctrl_word = ctrl_mc_load();
`ifdef CTRL_MEMCPY_EN
            mc_active = 1'b1;
`endif
          end else begin
            ctrl_word     = dec_ctrl;
            illegal_instr = dec_illegal;
          end
        end
`ifdef CTRL_MEMCPY_EN
        ST_MC_LOAD: begin
          ctrl_word = ctrl_mc_load();
          mc_active = 1'b1;
        end
        ST_MC_STORE: begin
          ctrl_word = ctrl_mc_store();
          mc_active = 1'b1;
        end
`endif
        default: ctrl_word = ctrl_boot();
      endcase
    end
  end

  always_comb begin
    out_word = ctrl_word;
`ifndef CTRL_MEMCPY_EN
    out_word.memcpy_store = 1'b0;
    out_word.counter_en   = 1'b0;
    out_word.counter_sel  = 1'b0;
`endif
  end

  assign ctrl_signals = out_word;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed bench for ctrl_fsm: decode vector table plus hand-written reset and
// memcpy sequences (memcpy sequences only when CTRL_MEMCPY_EN is defined).
module tb_ctrl_fsm;
  import ctrl_pkg::*;

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        ex_no_stay;
  logic [20:0] ctrl_signals;
  logic        illegal_instr;
  logic        mc_active;

  int n_checks = 0;
  int n_fail   = 0;
  logic [20:0] exp_q[$];

  typedef struct {
    logic [31:0] instr;
    logic [20:0] ctrl;
    logic        ill;
  } vec_t;
  vec_t vecs[$];

  ctrl_fsm dut (
    .clk           (clk),
    .rst           (rst),
    .instruction   (instruction),
    .ex_no_stay    (ex_no_stay),
    .ctrl_signals  (ctrl_signals),
    .illegal_instr (illegal_instr),
    .mc_active     (mc_active)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  // Control word built in bus bit order, independent of the RTL struct.
  function automatic logic [20:0] cw(input logic we, input logic [3:0] alu,
                                     input logic bs, input logic as_,
                                     input logic mw, input logic mr,
                                     input logic [1:0] ls, input logic lu,
                                     input logic [1:0] ws, input logic [2:0] br,
                                     input logic st, input logic ms,
                                     input logic ce, input logic cs);
    return {we, alu, bs, as_, mw, mr, ls, lu, ws, br, st, ms, ce, cs};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [20:0] c, input logic ill,
                            input logic mca);
    chk({tag, ".ctrl"}, {11'd0, ctrl_signals}, {11'd0, c});
    chk({tag, ".illegal"}, {31'd0, illegal_instr}, {31'd0, ill});
    chk({tag, ".mc_active"}, {31'd0, mc_active}, {31'd0, mca});
  endtask

  // Driver: new inputs just after the edge, sampling on the falling edge.
  task automatic drive(input logic [31:0] ins, input logic ens, input logic r);
    @(posedge clk);
    #1;
    instruction = ins;
    ex_no_stay  = ens;
    rst         = r;
    @(negedge clk);
  endtask

  logic [20:0] w_boot, w_add, w_mcl, w_mcs;
  localparam logic [31:0] I_ADD = 32'h007302B3;
  localparam logic [31:0] I_MC  = 32'h0000000B;

  initial begin
    rst         = 1'b1;
    instruction = I_ADD;
    ex_no_stay  = 1'b0;

    w_boot = cw(N, ALU_ADD, N, N, N, N, LS_BYTE, N, WS_ALU, BR_NONE, Y, N, N, N);
    w_add  = cw(Y, ALU_ADD, N, N, N, N, LS_BYTE, N, WS_ALU, BR_NONE, N, N, N, N);
    w_mcl  = cw(Y, ALU_ADD, Y, N, N, Y, LS_BYTE, N, WS_MEM, BR_NONE, Y, N, N, Y);
    w_mcs  = cw(N, ALU_ADD, Y, N, Y, N, LS_BYTE, N, WS_ALU, BR_NONE, Y, Y, Y, Y);

    vecs.push_back('{32'h007302B3, w_add, N});
    vecs.push_back('{32'h407302B3, cw(Y, ALU_SUB,  N, N, N, N, LS_BYTE, N, WS_ALU, BR_NONE, N, N, N, N), N});
    vecs.push_back('{32'h407352B3, cw(Y, ALU_SRA,  N, N, N, N, LS_BYTE, N, WS_ALU, BR_NONE, N, N, N, N), N});
    vecs.push_back('{32'h007352B3, cw(Y, ALU_SRL,  N, N, N, N, LS_BYTE, N, WS_ALU, BR_NONE, N, N, N, N), N});
    vecs.push_back('{32'h007372B3, cw(Y, ALU_AND,  N, N, N, N, LS_BYTE, N, WS_ALU, BR_NONE, N, N, N, N), N});
    vecs.push_back('{32'h007332B3, cw(Y, ALU_SLTU, N, N, N, N, LS_BYTE, N, WS_ALU, BR_NONE, N, N, N, N), N});
    vecs.push_back('{32'h00130293, cw(Y, ALU_ADD,  Y, N, N, N, LS_BYTE, N, WS_ALU, BR_NONE, N, N, N, N), N});
    vecs.push_back('{32'h40030293, cw(Y, ALU_ADD,  Y, N, N, N, LS_BYTE, N, WS_ALU, BR_NONE, N, N, N, N), N});
    vecs.push_back('{32'h40335293, cw(Y, ALU_SRA,  Y, N, N, N, LS_BYTE, N, WS_ALU, BR_NONE, N, N, N, N), N});
    vecs.push_back('{32'h00132293, cw(Y, ALU_SLT,  Y, N, N, N, LS_BYTE, N, WS_ALU, BR_NONE, N, N, N, N), N});
    vecs.push_back('{32'h123452B7, cw(Y, ALU_PASSB, Y, N, N, N, LS_BYTE, N, WS_ALU, BR_NONE, N, N, N, N), N});
    vecs.push_back('{32'h00001297, cw(Y, ALU_ADD,  Y, Y, N, N, LS_BYTE, N, WS_ALU, BR_NONE, N, N, N, N), N});
    vecs.push_back('{32'h00032283, cw(Y, ALU_ADD,  Y, N, N, Y, LS_WORD, N, WS_MEM, BR_NONE, N, N, N, N), N});
    vecs.push_back('{32'h00034283, cw(Y, ALU_ADD,  Y, N, N, Y, LS_BYTE, Y, WS_MEM, BR_NONE, N, N, N, N), N});
    vecs.push_back('{32'h00031283, cw(Y, ALU_ADD,  Y, N, N, Y, LS_HALF, N, WS_MEM, BR_NONE, N, N, N, N), N});
    vecs.push_back('{32'h0062A023, cw(N, ALU_ADD,  Y, N, Y, N, LS_WORD, N, WS_ALU, BR_NONE, N, N, N, N), N});
    vecs.push_back('{32'h00628023, cw(N, ALU_ADD,  Y, N, Y, N, LS_BYTE, N, WS_ALU, BR_NONE, N, N, N, N), N});
    vecs.push_back('{32'h00629023, cw(N, ALU_ADD,  Y, N, Y, N, LS_HALF, N, WS_ALU, BR_NONE, N, N, N, N), N});
    vecs.push_back('{32'h00628063, cw(N, ALU_SUB,  N, N, N, N, LS_BYTE, N, WS_ALU, BR_BEQ,  N, N, N, N), N});
    vecs.push_back('{32'h00629063, cw(N, ALU_SUB,  N, N, N, N, LS_BYTE, N, WS_ALU, BR_BNE,  N, N, N, N), N});
    vecs.push_back('{32'h0062C063, cw(N, ALU_SUB,  N, N, N, N, LS_BYTE, N, WS_ALU, BR_BLT,  N, N, N, N), N});
    vecs.push_back('{32'h0062D063, cw(N, ALU_SUB,  N, N, N, N, LS_BYTE, N, WS_ALU, BR_BGE,  N, N, N, N), N});
    vecs.push_back('{32'h0062E063, cw(N, ALU_SUB,  N, N, N, N, LS_BYTE, N, WS_ALU, BR_BLTU, N, N, N, N), N});
    vecs.push_back('{32'h0062F063, cw(N, ALU_SUB,  N, N, N, N, LS_BYTE, N, WS_ALU, BR_BGEU, N, N, N, N), N});
    vecs.push_back('{32'h0000006F, cw(Y, ALU_ADD,  Y, Y, N, N, LS_BYTE, N, WS_PC4, BR_JUMP, N, N, N, N), N});
    vecs.push_back('{32'h000280E7, cw(Y, ALU_ADD,  Y, N, N, N, LS_BYTE, N, WS_PC4, BR_JUMP, N, N, N, N), N});
    vecs.push_back('{32'hFFFFFFFF, 21'd0, Y});
    vecs.push_back('{32'h00000000, 21'd0, Y});
    vecs.push_back('{32'h0000100B, 21'd0, Y});
`ifndef CTRL_MEMCPY_EN
    vecs.push_back('{I_MC, 21'd0, Y});
`endif

    // Reset held three cycles, then the boot bubble, then the first ADD
    for (int i = 0; i < 3; i++) begin
      drive(I_ADD, N, Y);
      expect_out($sformatf("rst_hold%0d", i), w_boot, N, N);
    end
    drive(I_ADD, N, N);
    expect_out("boot_bubble", w_boot, N, N);
    drive(I_ADD, N, N);
    expect_out("first_add", w_add, N, N);

    // Decode table through the scoreboard queue
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].instr, N, N);
      exp_q.push_back(vecs[i].ctrl);
      chk($sformatf("vec%0d.ctrl", i), {11'd0, ctrl_signals}, {11'd0, exp_q.pop_front()});
      chk($sformatf("vec%0d.illegal", i), {31'd0, illegal_instr}, {31'd0, vecs[i].ill});
      chk($sformatf("vec%0d.mc_active", i), {31'd0, mc_active}, 32'd0);
    end

`ifdef CTRL_MEMCPY_EN
    // Three-element copy; ex_no_stay during a load must be ignored
    drive(I_MC, N, N); expect_out("mc3_load0",  w_mcl, N, Y);
    drive(I_MC, N, N); expect_out("mc3_store0", w_mcs, N, Y);
    drive(I_MC, Y, N); expect_out("mc3_load1",  w_mcl, N, Y);
    drive(I_MC, N, N); expect_out("mc3_store1", w_mcs, N, Y);
    drive(I_MC, N, N); expect_out("mc3_load2",  w_mcl, N, Y);
    drive(I_MC, Y, N); expect_out("mc3_store2", w_mcs, N, Y);
    drive(I_ADD, N, N); expect_out("mc3_after", w_add, N, N);

    // Single pair, then a back-to-back memcpy with reset during its store
    drive(I_MC, N, N);  expect_out("mc1_load",   w_mcl, N, Y);
    drive(I_MC, Y, N);  expect_out("mc1_store",  w_mcs, N, Y);
    drive(I_MC, N, N);  expect_out("b2b_load",   w_mcl, N, Y);
    drive(I_MC, N, Y);  expect_out("rst_in_store", w_boot, N, N);
    drive(I_ADD, N, N); expect_out("rst_boot",   w_boot, N, N);
    drive(I_ADD, N, N); expect_out("rst_exec",   w_add, N, N);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
